// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with tear-free frame commit and 16-level PWM.
// Optional build macro: SS_LEADING_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLK100MHZ,
  input  logic        Reset,
  input  logic [15:0] Digits,
  input  logic [3:0]  DP,
  input  logic        Load,
  input  logic [3:0]  Brightness,
  output logic [3:0]  SS_AN,
  output logic [7:0]  SS_CAT,
  output logic        FrameSync
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam int PWM_STEP = SCAN_DIV / 16;

  // Active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [15:0]      pend_digits_reg, pend_digits_next;
  logic [3:0]       pend_dp_reg, pend_dp_next;
  logic             pend_flag_reg, pend_flag_next;
  logic [15:0]      shadow_digits_reg, shadow_digits_next;
  logic [3:0]       shadow_dp_reg, shadow_dp_next;
  logic [3:0]       ss_an_reg, ss_an_next;
  logic [7:0]       ss_cat_reg, ss_cat_next;
  logic             frame_sync_reg;

  logic             slot_end;
  logic             frame_end;
  logic             lit;
  logic [31:0]      lit_limit;
  logic [6:0]       seg_code [4];
  logic [3:0]       blank;

  // Slot counter and digit index
  always_comb begin
    slot_end  = (cnt_reg == CNT_LAST);
    frame_end = slot_end && (idx_reg == 2'd3);
    cnt_next  = slot_end ? '0 : cnt_reg + 1'b1;
    idx_next  = slot_end ? idx_reg + 2'd1 : idx_reg;
  end

  // Pending/shadow buffering: display content only changes between frames
  always_comb begin
    pend_digits_next   = pend_digits_reg;
    pend_dp_next       = pend_dp_reg;
    pend_flag_next     = pend_flag_reg;
    shadow_digits_next = shadow_digits_reg;
    shadow_dp_next     = shadow_dp_reg;
    if (frame_end) begin
      if (Load) begin
        shadow_digits_next = Digits;
        shadow_dp_next     = DP;
      end else if (pend_flag_reg) begin
        shadow_digits_next = pend_digits_reg;
        shadow_dp_next     = pend_dp_reg;
      end
      pend_flag_next = 1'b0;
    end else if (Load) begin
      pend_digits_next = Digits;
      pend_dp_next     = DP;
      pend_flag_next   = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign seg_code[gi] = seg_decode(shadow_digits_reg[4*gi +: 4]);
`ifdef SS_LEADING_BLANK_EN
      if (gi == 0) begin : g_never_blank
        assign blank[gi] = 1'b0;
      end else begin : g_lead_blank
        // Blank when this digit and every digit to its left are zero
        assign blank[gi] = (shadow_digits_reg[15:4*gi] == '0);
      end
`else
      assign blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // Pin drive for the next cycle, derived from the current slot position
  always_comb begin
    lit_limit   = (32'(Brightness) + 32'd1) * 32'(PWM_STEP);
    lit         = (32'(cnt_reg) < lit_limit);
    ss_an_next  = 4'hF;
    ss_cat_next = 8'hFF;
    if (lit) begin
      ss_an_next  = ~(4'b0001 << idx_reg);
      ss_cat_next = {~shadow_dp_reg[idx_reg], blank[idx_reg] ? 7'h7F : seg_code[idx_reg]};
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      cnt_reg           <= '0;
      idx_reg           <= '0;
      pend_digits_reg   <= '0;
      pend_dp_reg       <= '0;
      pend_flag_reg     <= 1'b0;
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      ss_an_reg         <= 4'hF;
      ss_cat_reg        <= 8'hFF;
      frame_sync_reg    <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      idx_reg           <= idx_next;
      pend_digits_reg   <= pend_digits_next;
      pend_dp_reg       <= pend_dp_next;
      pend_flag_reg     <= pend_flag_next;
      shadow_digits_reg <= shadow_digits_next;
      shadow_dp_reg     <= shadow_dp_next;
      ss_an_reg         <= ss_an_next;
      ss_cat_reg        <= ss_cat_next;
      frame_sync_reg    <= frame_end;
    end
  end

  assign SS_AN     = ss_an_reg;
  assign SS_CAT    = ss_cat_reg;
  assign FrameSync = frame_sync_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (SCAN_DIV=16): directed and random steps against a time-based display model.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int DIV   = 16;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] Digits;
  logic [3:0]  DP;
  logic        Load;
  logic [3:0]  Brightness;
  logic [3:0]  SS_AN;
  logic [7:0]  SS_CAT;
  logic        FrameSync;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: elapsed cycles since reset plus the two buffers
  int          tick = 0;
  logic [15:0] m_shadow_d = '0;
  logic [3:0]  m_shadow_dp = '0;
  logic [15:0] m_pend_d = '0;
  logic [3:0]  m_pend_dp = '0;
  bit          m_pend = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .CLK100MHZ (clk),
    .Reset     (Reset),
    .Digits    (Digits),
    .DP        (DP),
    .Load      (Load),
    .Brightness(Brightness),
    .SS_AN     (SS_AN),
    .SS_CAT    (SS_CAT),
    .FrameSync (FrameSync)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic [3:0] exp_an;
    logic [7:0] exp_cat;
    logic       exp_fs;
    int         pos, idx;
    bit         boundary, blanked;
    logic [3:0] code;
    pos      = tick % DIV;
    idx      = (tick / DIV) % 4;
    boundary = (tick % FRAME) == FRAME - 1;
    exp_an   = 4'hF;
    exp_cat  = 8'hFF;
    exp_fs   = 1'b0;
    if (!Reset) begin
      exp_fs = boundary;
      if (pos < (int'(Brightness) + 1) * (DIV / 16)) begin
        exp_an  = 4'hF ^ 4'(1 << idx);
        code    = 4'((m_shadow_d >> (4 * idx)) & 16'hF);
`ifdef SS_LEADING_BLANK_EN
        blanked = (idx > 0) && ((m_shadow_d >> (4 * idx)) == 16'h0);
`else
        blanked = 1'b0;
`endif
        exp_cat = {~m_shadow_dp[idx], blanked ? 7'h7F : seg_tab[code]};
      end
    end
    @(posedge clk);
    if (Reset) begin
      tick = 0; m_shadow_d = '0; m_shadow_dp = '0; m_pend_d = '0; m_pend_dp = '0; m_pend = 1'b0;
    end else begin
      if (boundary) begin
        if (Load) begin
          m_shadow_d = Digits; m_shadow_dp = DP;
        end else if (m_pend) begin
          m_shadow_d = m_pend_d; m_shadow_dp = m_pend_dp;
        end
        m_pend = 1'b0;
      end else if (Load) begin
        m_pend_d = Digits; m_pend_dp = DP; m_pend = 1'b1;
      end
      tick++;
    end
    #1;
    n_assert++;
    assert (SS_AN === exp_an) else begin
      n_fail++;
      $error("FAIL ss_an tick=%0d observed=%h expected=%h", tick, SS_AN, exp_an);
    end
    n_assert++;
    assert (SS_CAT === exp_cat) else begin
      n_fail++;
      $error("FAIL ss_cat tick=%0d observed=%h expected=%h", tick, SS_CAT, exp_cat);
    end
    n_assert++;
    assert (FrameSync === exp_fs) else begin
      n_fail++;
      $error("FAIL frame_sync tick=%0d observed=%b expected=%b", tick, FrameSync, exp_fs);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] dp);
    Digits = d;
    DP     = dp;
    Load   = 1'b1;
    step();
    Load   = 1'b0;
  endtask

  // Advance until the next cycle is the last cycle of a frame
  task automatic run_to_boundary();
    while ((tick % FRAME) != FRAME - 1) step();
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; Digits = '0; DP = '0; Brightness = 4'd15;
    run(3);
    Reset = 1'b0;
    run(20);
    // Load mid-frame, committed at the next boundary
    load_pulse(16'h1234, 4'b0000);
    run(2 * FRAME);
    // Two loads in one frame: last wins
    run(5);
    load_pulse(16'h1111, 4'b0000);
    run(10);
    load_pulse(16'h2222, 4'b0000);
    run(2 * FRAME);
    // Load exactly on the boundary cycle commits that frame
    run_to_boundary();
    load_pulse(16'hABCD, 4'b1010);
    run(FRAME + 3);
    // Dim levels
    Brightness = 4'd0;
    run(FRAME);
    Brightness = 4'd7;
    run(FRAME);
    Brightness = 4'd15;
    // Leading zeros with a decimal point on digit 0
    load_pulse(16'h000F, 4'b0001);
    run(2 * FRAME);
    load_pulse(16'h0E05, 4'b1100);
    run(2 * FRAME);
    // Random traffic
    for (int i = 0; i < 500; i++) begin
      Load       = ($urandom_range(0, 7) == 0);
      Digits     = 16'($urandom);
      DP         = 4'($urandom);
      Brightness = 4'($urandom);
      step();
    end
    Load = 1'b0; Brightness = 4'd15;
    run(FRAME);
    // Reset mid-frame after a load discards pending and shadow
    run(7);
    load_pulse(16'h5678, 4'b1111);
    run(5);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    run(2 * FRAME);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
